lap_timer: RTL and testbench

LAP_TIMER -- requirements
Module: lap_timer

---
 rtl/lap_timer_pkg.sv | 44 ++++
 rtl/lap_timer_bcd_pair.sv | 71 +++++++
 rtl/lap_timer.sv | 192 +++++++++++++++++++
 tb/tb_lap_timer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/lap_timer_pkg.sv
// lap_timer_pkg: state encoding, pair radix constants and BCD helper functions
// shared by the lap timer top and its BCD pair counters.
package lap_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  localparam int RADIX_100 = 100;
  localparam int RADIX_60  = 60;

  // Pair 0 counts hundredths, pairs 1 and 2 count seconds and minutes,
  // everything above counts in plain hundreds.
  function automatic int pair_radix(input int k);
    int r;
    if ((k == 1) || (k == 2)) begin
      r = RADIX_60;
    end else begin
      r = RADIX_100;
    end
    return r;
  endfunction

  // Clamp a preset pair: low digit to 9, high digit to the pair's top digit.
  function automatic logic [7:0] sat_bcd_pair(input logic [7:0] v, input logic [3:0] hi_max);
    logic [3:0] hi;
    logic [3:0] lo;
    if (v[7:4] > hi_max) begin
      hi = hi_max;
    end else begin
      hi = v[7:4];
    end
    if (v[3:0] > 4'd9) begin
      lo = 4'd9;
    end else begin
      lo = v[3:0];
    end
    return {hi, lo};
  endfunction

endpackage

// File: rtl/lap_timer_bcd_pair.sv
// bcd_pair_counter: one two-digit BCD counter of a given radix (60 or 100).
// Counts up or down when enabled and reports carry/borrow combinationally so
// the next pair can step in the same cycle.
module bcd_pair_counter
  import lap_timer_pkg::*;
#(
  parameter int RADIX = 100
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic       i_up,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  output logic [7:0] o_val,
  output logic [7:0] o_next,
  output logic       o_carry
);

  localparam logic [3:0] HI_MAX = 4'((RADIX - 1) / 10);

  logic [7:0] r_val;
  logic [7:0] w_next;
  logic       w_at_term;

  // Next pair value: clear beats load beats count; terminal value wraps.
  always_comb begin
    w_at_term = i_up ? (r_val == {HI_MAX, 4'd9}) : (r_val == 8'd0);
    o_carry   = i_en & w_at_term;
    w_next    = r_val;
    if (i_clr) begin
      w_next = 8'd0;
    end else if (i_load) begin
      w_next = sat_bcd_pair(i_load_val, HI_MAX);
    end else if (i_en) begin
      if (i_up) begin
        if (w_at_term) begin
          w_next = 8'd0;
        end else if (r_val[3:0] == 4'd9) begin
          w_next = {r_val[7:4] + 4'd1, 4'd0};
        end else begin
          w_next = {r_val[7:4], r_val[3:0] + 4'd1};
        end
      end else begin
        if (w_at_term) begin
          w_next = {HI_MAX, 4'd9};
        end else if (r_val[3:0] == 4'd0) begin
          w_next = {r_val[7:4] - 4'd1, 4'd9};
        end else begin
          w_next = {r_val[7:4], r_val[3:0] - 4'd1};
        end
      end
    end else begin
      w_next = r_val;
    end
  end

  // Pair value register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_val <= 8'd0;
    end else begin
      r_val <= w_next;
    end
  end

  assign o_val  = r_val;
  assign o_next = w_next;

endmodule

// File: rtl/lap_timer.sv
// lap_timer: BCD stopwatch / countdown timer with lap freeze.
// A prescaler produces ticks in RUN; a chain of BCD pair counters holds the
// count; outputs are registered from next-state values so the display
// follows a tick or event by exactly one cycle.
module lap_timer
  import lap_timer_pkg::*;
#(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 100,
  parameter int DIGITS  = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_lap,
  input  logic                  i_clear,
  input  logic                  i_mode,
  input  logic                  i_load,
  input  logic [4*DIGITS-1:0]   i_load_data,
  output logic [4*DIGITS-1:0]   o_data,
  output logic                  o_running,
  output logic                  o_lap,
  output logic                  o_expired,
  output logic                  o_wrap
);

  localparam int DW     = 4 * DIGITS;
  localparam int NPAIRS = DIGITS / 2;
  localparam int PDIV   = CLK_HZ / TICK_HZ;
  localparam int PW     = (PDIV > 1) ? $clog2(PDIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PDIV - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_presc;
  logic [PW-1:0] w_presc_nxt;
  logic          r_mode;
  logic          w_mode_nxt;
  logic          r_lap;
  logic          w_lap_nxt;
  logic [DW-1:0] r_lap_val;
  logic [DW-1:0] w_lap_val_nxt;

  logic [DW-1:0] w_count;
  logic [DW-1:0] w_count_next;
  logic          w_tick;
  logic          w_do_load;
  logic          w_start_ev;
  logic          w_lap_ev;
  logic          w_hit_zero;
  logic          w_top_carry;

  // Event decode with priority clear > load > start > lap.
  assign w_do_load  = i_load & ~i_clear & (r_state == ST_IDLE);
  assign w_start_ev = i_start & ~i_clear & ~i_load;
  assign w_lap_ev   = i_lap & ~i_clear & ~i_load & ~i_start;
  assign w_tick     = (r_state == ST_RUN) & (r_presc == PRESC_MAX) & ~i_clear;
  assign w_hit_zero = w_tick & r_mode & (w_count == DW'(1));

  genvar k;
  for (k = 0; k < NPAIRS; k++) begin : g_pair
    logic w_en;
    logic w_carry;
    if (k == 0) begin : g_first
      assign w_en = w_tick;
    end else begin : g_rest
      assign w_en = g_pair[k-1].w_carry;
    end
    bcd_pair_counter #(
      .RADIX (pair_radix(k))
    ) u_pair (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_clr      (i_clear),
      .i_en       (w_en),
      .i_up       (~r_mode),
      .i_load     (w_do_load),
      .i_load_val (i_load_data[8*k +: 8]),
      .o_val      (w_count[8*k +: 8]),
      .o_next     (w_count_next[8*k +: 8]),
      .o_carry    (w_carry)
    );
  end

  assign w_top_carry = g_pair[NPAIRS-1].w_carry;

  // Next state, mode latch, lap register and prescaler decisions.
  always_comb begin
    w_state_nxt   = r_state;
    w_presc_nxt   = {PW{1'b0}};
    w_mode_nxt    = r_mode;
    w_lap_nxt     = r_lap;
    w_lap_val_nxt = r_lap_val;
    if (i_clear) begin
      w_state_nxt   = ST_IDLE;
      w_lap_nxt     = 1'b0;
      w_lap_val_nxt = {DW{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_mode_nxt = i_mode;
          // A countdown from zero has nothing to run.
          if (w_start_ev && !(i_mode && (w_count == {DW{1'b0}}))) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (w_hit_zero) begin
            w_state_nxt = ST_EXPIRED;
          end else if (w_start_ev) begin
            w_state_nxt = ST_PAUSE;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_PAUSE: begin
          if (w_start_ev) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_state_nxt = ST_PAUSE;
          end
        end
        ST_EXPIRED: begin
          w_state_nxt = ST_EXPIRED;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase

      // Lap toggles freeze only while the timer is active (running or paused).
      if (w_lap_ev && ((r_state == ST_RUN) || (r_state == ST_PAUSE))) begin
        if (r_lap) begin
          w_lap_nxt = 1'b0;
        end else begin
          w_lap_nxt     = 1'b1;
          w_lap_val_nxt = w_count;
        end
      end else begin
        w_lap_nxt = r_lap;
      end

      // Prescaler only runs while staying in RUN; any other case parks it at 0.
      if ((r_state == ST_RUN) && (w_state_nxt == ST_RUN)) begin
        if (w_tick) begin
          w_presc_nxt = {PW{1'b0}};
        end else begin
          w_presc_nxt = r_presc + PW'(1);
        end
      end else begin
        w_presc_nxt = {PW{1'b0}};
      end
    end
  end

  // Control state registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_presc   <= {PW{1'b0}};
      r_mode    <= 1'b0;
      r_lap     <= 1'b0;
      r_lap_val <= {DW{1'b0}};
    end else begin
      r_state   <= w_state_nxt;
      r_presc   <= w_presc_nxt;
      r_mode    <= w_mode_nxt;
      r_lap     <= w_lap_nxt;
      r_lap_val <= w_lap_val_nxt;
    end
  end

  // Registered outputs, driven from next-state values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_data    <= {DW{1'b0}};
      o_running <= 1'b0;
      o_lap     <= 1'b0;
      o_expired <= 1'b0;
      o_wrap    <= 1'b0;
    end else begin
      o_data    <= w_lap_nxt ? w_lap_val_nxt : w_count_next;
      o_running <= (w_state_nxt == ST_RUN);
      o_lap     <= w_lap_nxt;
      o_expired <= (w_state_nxt == ST_EXPIRED);
      o_wrap    <= w_tick & ~r_mode & w_top_carry;
    end
  end

endmodule

// File: tb/tb_lap_timer.sv
// tb_lap_timer: directed stimulus with a scoreboard queue. The stimulus
// process pushes the hand-computed expected outputs; a monitor on the falling
// edge pops each entry and compares it with the DUT outputs.
module tb_lap_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        lap = 1'b0;
  logic        clear = 1'b0;
  logic        mode = 1'b0;
  logic        load = 1'b0;
  logic [23:0] load_data = 24'h0;
  logic [23:0] data;
  logic        running;
  logic        lapo;
  logic        expired;
  logic        wrap;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [23:0] data;
    logic        running;
    logic        lap;
    logic        expired;
    logic        wrap;
  } exp_t;

  exp_t exp_q[$];
  exp_t m_e;

  lap_timer #(
    .CLK_HZ  (1000),
    .TICK_HZ (100),
    .DIGITS  (6)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_lap       (lap),
    .i_clear     (clear),
    .i_mode      (mode),
    .i_load      (load),
    .i_load_data (load_data),
    .o_data      (data),
    .o_running   (running),
    .o_lap       (lapo),
    .o_expired   (expired),
    .o_wrap      (wrap)
  );

  always #5 clk = ~clk;

  // Monitor: compare DUT outputs against the oldest queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      m_e = exp_q.pop_front();
      checks++;
      if ((data !== m_e.data) || (running !== m_e.running) || (lapo !== m_e.lap) ||
          (expired !== m_e.expired) || (wrap !== m_e.wrap)) begin
        errors++;
        $display("FAIL %s: got data=%h run=%b lap=%b exp=%b wrap=%b, want data=%h run=%b lap=%b exp=%b wrap=%b",
                 m_e.name, data, running, lapo, expired, wrap,
                 m_e.data, m_e.running, m_e.lap, m_e.expired, m_e.wrap);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic s, input logic lp, input logic c, input logic ld);
    start = s;
    lap   = lp;
    clear = c;
    load  = ld;
    step(1);
    start = 1'b0;
    lap   = 1'b0;
    clear = 1'b0;
    load  = 1'b0;
  endtask

  task automatic chk(input string name, input logic [23:0] d, input logic r,
                     input logic l, input logic e, input logic w);
    exp_t x;
    x.name    = name;
    x.data    = d;
    x.running = r;
    x.lap     = l;
    x.expired = e;
    x.wrap    = w;
    exp_q.push_back(x);
    @(negedge clk);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed stimulus.
  initial begin
    step(3);
    chk("reset", 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Basic up count: first tick 10 cycles after entering RUN.
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    chk("start_run", 24'h000000, 1'b1, 1'b0, 1'b0, 1'b0);
    step(9);
    chk("pre_tick", 24'h000000, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1);
    chk("first_tick", 24'h000001, 1'b1, 1'b0, 1'b0, 1'b0);
    step(990);
    chk("hundred_ticks", 24'h000100, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    chk("clear_idle", 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Pause mid-period restarts the prescaler on resume; load ignored in RUN.
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    step(5);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    chk("paused", 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0);
    step(20);
    chk("pause_hold", 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    step(9);
    chk("resume_pre", 24'h000000, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1);
    chk("resume_tick", 24'h000001, 1'b1, 1'b0, 1'b0, 1'b0);
    load_data = 24'h123456;
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    chk("load_in_run", 24'h000001, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);

    // Load saturation and load-over-start priority.
    load_data = 24'hA5F3C7;
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    chk("sat_hex", 24'h555397, 1'b0, 1'b0, 1'b0, 1'b0);
    load_data = 24'h995958;
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    chk("sat_60", 24'h595958, 1'b0, 1'b0, 1'b0, 1'b0);
    load_data = 24'h000007;
    pulse(1'b1, 1'b0, 1'b0, 1'b1);
    chk("load_beats_start", 24'h000007, 1'b0, 1'b0, 1'b0, 1'b0);

    // Up-count roll-over from the all-max value 59:59:99.
    load_data = 24'h595998;
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    chk("wrap_start", 24'h595998, 1'b1, 1'b0, 1'b0, 1'b0);
    step(10);
    chk("wrap_max", 24'h595999, 1'b1, 1'b0, 1'b0, 1'b0);
    step(10);
    chk("wrap_zero", 24'h000000, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1);
    chk("wrap_once", 24'h000000, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);

    // Down count borrowing across radix-60 pairs.
    mode = 1'b1;
    load_data = 24'h010000;
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    step(10);
    chk("borrow", 24'h005999, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);

    // Down count to expiry.
    load_data = 24'h000003;
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    step(10);
    chk("down_2", 24'h000002, 1'b1, 1'b0, 1'b0, 1'b0);
    step(10);
    chk("down_1", 24'h000001, 1'b1, 1'b0, 1'b0, 1'b0);
    step(10);
    chk("expired", 24'h000000, 1'b0, 1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    step(20);
    chk("expired_hold", 24'h000000, 1'b0, 1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    chk("down_zero_start", 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0);
    mode = 1'b0;

    // Lap freeze and release while the live count advances.
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    step(420);
    chk("lap_pre", 24'h000042, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    chk("lap_freeze", 24'h000042, 1'b1, 1'b1, 1'b0, 1'b0);
    step(80);
    chk("lap_hold", 24'h000042, 1'b1, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    chk("lap_release", 24'h000050, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    chk("lap_again", 24'h000050, 1'b1, 1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b1, 1'b1, 1'b0);
    chk("clear_priority", 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset in RUN with a frozen lap.
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    step(30);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    chk("lap_before_rst", 24'h000003, 1'b1, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    step(1);
    chk("rst_in_run", 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step(15);
    chk("idle_after_rst", 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
